// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, coefficient indices and fixed-point helpers for the biquad cascade
package iir_pkg;

  typedef enum logic [2:0] {IDLE, PRE, MAC, POST, HOLD} state_t;

  typedef enum logic [1:0] {MAC_LOAD, MAC_ADD, MAC_SUB} mac_op_t;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  // All intermediate arithmetic is done in 64 bits, then clamped to the target width.
  typedef logic signed [63:0] wide_t;

  function automatic wide_t sat_hi(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_lo(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic wide_t saturate(input wide_t x, input int w);
    if (x > sat_hi(w)) return sat_hi(w);
    if (x < sat_lo(w)) return sat_lo(w);
    return x;
  endfunction

  function automatic logic sat_ovf(input wide_t x, input int w);
    return (x > sat_hi(w)) || (x < sat_lo(w));
  endfunction

  // Round half up: -1.5 becomes -1.
  function automatic wide_t round_shift(input wide_t x, input int frac);
    return (x + (wide_t'(1) <<< (frac - 1))) >>> frac;
  endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// rtl/iir_biquad_cascade_if.sv - sample streams and coefficient write bus of the biquad cascade
interface iir_biquad_cascade_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] y_out;
  logic                     coef_we;
  logic [2:0]               coef_sec;
  logic [2:0]               coef_idx;
  logic signed [DATA_W-1:0] coef_data;
  logic                     coef_ready;

  modport master (
    output in_valid, x_in, out_ready, coef_we, coef_sec, coef_idx, coef_data,
    input  in_ready, out_valid, y_out, coef_ready
  );

  modport slave (
    input  in_valid, x_in, out_ready, coef_we, coef_sec, coef_idx, coef_data,
    output in_ready, out_valid, y_out, coef_ready
  );
endinterface

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - one multiply per cycle with saturating ACC_W add/subtract into a result register
module iir_mac
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2 * DATA_W + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  mac_op_t                 op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  addend,
  output logic signed [ACC_W-1:0]  sum,
  output logic signed [ACC_W-1:0]  acc,
  output logic                    ovf
);

  wide_t prod;
  wide_t base;
  wide_t raw;

  // LOAD starts from an external addend, ADD/SUB continue from the previous result.
  always_comb begin
    prod = wide_t'(a) * wide_t'(b);
    base = (op == MAC_LOAD) ? wide_t'(addend) : wide_t'(acc);
    raw  = (op == MAC_SUB) ? base - prod : base + prod;
    sum  = ACC_W'(saturate(raw, ACC_W));
    ovf  = sat_ovf(raw, ACC_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (en) acc <= sum;
  end

endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - cascade of transposed-DF2 biquads sharing one time-multiplexed MAC
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 14,
  parameter int SECTIONS   = 2,
  parameter int IN_OFFSET  = 0,
  parameter int OUT_OFFSET = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  iir_biquad_cascade_if.slave  bus,
  input  logic                 clear,
  output logic                 sat_sticky
);

  localparam int ACC_W = 2 * DATA_W + 4;
  localparam int SEC_W = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int NSLOT = 1 << SEC_W;

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam smp_t COEF_ONE = smp_t'(1 << FRAC_W);

  state_t           state;
  logic [SEC_W-1:0] sec;
  logic [2:0]       step;
  logic             in_rdy, out_vld, coef_rdy;
  smp_t             x_reg, v, y, y_out_r;
  smp_t             coef [NSLOT][5];
  acc_t             s1 [NSLOT];
  acc_t             s2 [NSLOT];

  mac_op_t mac_op;
  smp_t    mac_a, mac_b;
  acc_t    mac_add, mac_sum, mac_acc;
  logic    mac_ovf;
  wide_t   v0_w, y_w, o_w;
  logic    coef_hit;

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.y_out      = y_out_r;
  assign bus.coef_ready = coef_rdy;

  assign coef_hit = bus.coef_we && coef_rdy && (int'(bus.coef_sec) < SECTIONS)
                    && (bus.coef_idx <= COEF_A2);

  // Step schedule: b0*v+s1, b1*v+s2, -a1*y, b2*v, -a2*y.
  always_comb begin
    mac_op  = MAC_LOAD;
    mac_a   = coef[sec][COEF_B0];
    mac_b   = v;
    mac_add = '0;
    case (step)
      3'd0: mac_add = s1[sec];
      3'd1: begin mac_a = coef[sec][COEF_B1]; mac_add = s2[sec]; end
      3'd2: begin mac_op = MAC_SUB; mac_a = coef[sec][COEF_A1]; mac_b = y; end
      3'd3: mac_a = coef[sec][COEF_B2];
      default: begin mac_op = MAC_SUB; mac_a = coef[sec][COEF_A2]; mac_b = y; end
    endcase
    v0_w = wide_t'(x_reg) - wide_t'(IN_OFFSET);
    y_w  = round_shift(wide_t'(mac_acc), FRAC_W);
    o_w  = wide_t'(y) + wide_t'(OUT_OFFSET);
  end

  iir_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en     (state == MAC),
    .op     (mac_op),
    .a      (mac_a),
    .b      (mac_b),
    .addend (mac_add),
    .sum    (mac_sum),
    .acc    (mac_acc),
    .ovf    (mac_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSLOT; s++)
        for (int k = 0; k < 5; k++)
          coef[s][k] <= (k == 0) ? COEF_ONE : '0;
    end else if (coef_hit) begin
      coef[bus.coef_sec[SEC_W-1:0]][bus.coef_idx] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_rdy     <= 1'b1;
      coef_rdy   <= 1'b1;
      out_vld    <= 1'b0;
      y_out_r    <= '0;
      sat_sticky <= 1'b0;
      sec        <= '0;
      step       <= '0;
      x_reg      <= '0;
      v          <= '0;
      y          <= '0;
      for (int s = 0; s < NSLOT; s++) begin
        s1[s] <= '0;
        s2[s] <= '0;
      end
    end else begin
      // A clear with a same-cycle handshake zeroes state before the sample starts.
      if (clear && (state == IDLE || state == HOLD)) begin
        sat_sticky <= 1'b0;
        for (int s = 0; s < NSLOT; s++) begin
          s1[s] <= '0;
          s2[s] <= '0;
        end
      end
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg    <= bus.x_in;
            state    <= PRE;
            in_rdy   <= 1'b0;
            coef_rdy <= 1'b0;
          end
        end
        PRE: begin
          v    <= smp_t'(saturate(v0_w, DATA_W));
          if (sat_ovf(v0_w, DATA_W)) sat_sticky <= 1'b1;
          sec  <= '0;
          step <= '0;
          state <= MAC;
        end
        MAC: begin
          if (mac_ovf) sat_sticky <= 1'b1;
          case (step)
            3'd0: step <= 3'd1;
            3'd1: begin
              y <= smp_t'(saturate(y_w, DATA_W));
              if (sat_ovf(y_w, DATA_W)) sat_sticky <= 1'b1;
              step <= 3'd2;
            end
            3'd2: begin
              s1[sec] <= mac_sum;
              step    <= 3'd3;
            end
            3'd3: step <= 3'd4;
            default: begin
              s2[sec] <= mac_sum;
              v       <= y;
              step    <= '0;
              if (int'(sec) == SECTIONS - 1) state <= POST;
              else sec <= sec + 1'b1;
            end
          endcase
        end
        POST: begin
          y_out_r  <= smp_t'(saturate(o_w, DATA_W));
          if (sat_ovf(o_w, DATA_W)) sat_sticky <= 1'b1;
          out_vld  <= 1'b1;
          coef_rdy <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_rdy   <= 1'b1;
          coef_rdy <= 1'b1;
          out_vld  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - self-checking bench for iir_biquad_cascade
module tb_iir_biquad_cascade;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic sat_sticky;

  iir_biquad_cascade_if #(.DATA_W(16)) bus();

  iir_biquad_cascade #(
    .DATA_W(16), .FRAC_W(14), .SECTIONS(2), .IN_OFFSET(0), .OUT_OFFSET(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clear      (clear),
    .sat_sticky (sat_sticky)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; } vec_t;

  int     tests = 0;
  int     failed = 0;
  bit     rand_rdy = 1'b0;
  longint sb[$];
  longint mon_exp;
  longint mc [2][5];
  longint ms1 [2];
  longint ms2 [2];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        check("y_out", bus.y_out, mon_exp);
      end
    end
  end

  function automatic longint satw(input longint x, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model(input longint x, output longint y);
    longint v, acc, t, yy;
    v = satw(x, 16);
    for (int s = 0; s < 2; s++) begin
      acc = satw(mc[s][0] * v + ms1[s], 36);
      yy  = satw((acc + 8192) >>> 14, 16);
      t   = satw(mc[s][1] * v + ms2[s], 36);
      ms1[s] = satw(t - mc[s][3] * yy, 36);
      ms2[s] = satw(mc[s][2] * v - mc[s][4] * yy, 36);
      v = yy;
    end
    y = satw(v, 16);
  endtask

  task automatic rand_tick();
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input int x);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_in = 16'(x);
    for (int k = 0; k < 400 && !ok; k++) begin
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (!ok) rand_tick();
    end
    bus.in_valid = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 600 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
      rand_tick();
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic wcoef(input int s, input int idx, input int d);
    bus.coef_we = 1'b1;
    bus.coef_sec = 3'(s);
    bus.coef_idx = 3'(idx);
    bus.coef_data = 16'(d);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t   tv [5];
    int     n;
    bit     hold_ok;
    longint ym;
    int     xr;

    tv[0] = '{1000, 1000};
    tv[1] = '{1000, 1500};
    tv[2] = '{1000, 1750};
    tv[3] = '{1000, 1875};
    tv[4] = '{1000, 1938};

    bus.in_valid = 0; bus.x_in = 0; bus.out_ready = 1;
    bus.coef_we = 0; bus.coef_sec = 0; bus.coef_idx = 0; bus.coef_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset values, passthrough and latency
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y_out", bus.y_out, 0);
    check("rst_coef_ready", bus.coef_ready, 1);
    check("rst_sat_sticky", sat_sticky, 0);
    sb.push_back(1000);
    send(1000);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 12);
    drain();
    check("sticky_after_pass", sat_sticky, 0);

    // 2: one-pole section, step input, clear ignored mid-computation
    wcoef(0, 3, -8192);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(tv[i].y);
      send(tv[i].x);
      if (i == 2) begin
        repeat (3) @(posedge clk);
        #1 pulse_clear();
      end
    end
    drain();

    // 3: saturation, sticky flag and clear in IDLE
    wcoef(0, 0, 32767);
    pulse_clear();
    sb.push_back(32767);
    send(30000);
    drain();
    check("sticky_set", sat_sticky, 1);
    pulse_clear();
    check("sticky_cleared", sat_sticky, 0);
    sb.push_back(200);
    send(100);
    drain();

    // 4: back-pressure holds output, second sample waits for IDLE
    wcoef(0, 0, 16384);
    wcoef(0, 3, 0);
    pulse_clear();
    bus.out_ready = 1'b0;
    sb.push_back(1234);
    send(1234);
    sb.push_back(-777);
    bus.in_valid = 1'b1;
    bus.x_in = -16'sd777;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_out_valid", bus.out_valid, 1);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.y_out != 16'sd1234 || !bus.out_valid || bus.in_ready) hold_ok = 1'b0;
    end
    check("hold_stable", hold_ok, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("reidle_in_ready", bus.in_ready, 1);
    check("reidle_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("second_accepted", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    drain();

    // 5: coefficient writes dropped when busy or out of range
    sb.push_back(500);
    send(500);
    repeat (3) @(posedge clk);
    #1 check("busy_coef_ready", bus.coef_ready, 0);
    wcoef(0, 0, 8192);
    drain();
    sb.push_back(500);
    send(500);
    drain();
    check("idle_coef_ready", bus.coef_ready, 1);
    wcoef(0, 0, 8192);
    sb.push_back(250);
    send(500);
    drain();
    wcoef(2, 0, 0);
    wcoef(0, 5, 0);
    sb.push_back(250);
    send(500);
    drain();
    wcoef(0, 0, 16384);

    // 6: reset during section 1 step 2
    wcoef(0, 3, -8192);
    wcoef(1, 0, 8192);
    send(700);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_coef_ready", bus.coef_ready, 1);
    check("post_rst_sticky", sat_sticky, 0);
    sb.push_back(-500);
    send(-500);
    drain();

    // Random coefficients and samples against the reference model with random stalls
    for (int s = 0; s < 2; s++) begin
      ms1[s] = 0;
      ms2[s] = 0;
      for (int k = 0; k < 5; k++) begin
        if (k == 4) xr = int'($urandom_range(0, 14000)) - 4000;
        else xr = int'($urandom_range(0, 24000)) - 12000;
        mc[s][k] = xr;
        wcoef(s, k, xr);
      end
    end
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      xr = int'($urandom_range(0, 8000)) - 4000;
      model(xr, ym);
      sb.push_back(ym);
      send(xr);
    end
    drain();
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
